mux_alu_stage: RTL and testbench
================================

# mux_alu_stage

Downstream execution stage for the 4:1 operand mux. It takes the mux output plus a per-beat opcode and applies it against an internal accumulator. Results pass through a 2-entry output buffer with valid/ready handshake. It sits between the mux's `out`/`enb` and the result consumer, and decouples consumer back-pressure from the mux.

## Interface
Parameters:
- `WIDTH`, 8: data width; must match the mux data width.
- `DEPTH`, 2: output buffer entries; fixed at 2 for this revision.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — reset, asynchronous, active-high.
- `in_valid`  in  1  — beat present; driven from the mux `enb`.
- `in_ready`  out  1  — stage can accept a beat.
- `in_data`  in  WIDTH  — operand; the mux `out`.
- `in_op`  in  3  — opcode, encoded as `alu_op_e`.
- `out_valid`  out  1  — head of the output buffer is valid.
- `out_ready`  in  1  — consumer accepts the head.
- `out_data`  out  WIDTH  — result at the head.
- `out_carry`  out  1  — carry/borrow of the head result.
- `out_zero`  out  1  — head result equals 0.
- `acc`  out  WIDTH  — current accumulator value.

## Operation
- A beat is accepted when `in_valid && in_ready` at a rising edge; `in_data` and `in_op` are sampled only then.
- Opcodes (result R, accumulator A):
  - 0 PASS: R = in_data; A unchanged.
  - 1 ADD: R = A + in_data; carry = bit WIDTH of the sum.
  - 2 SUB: R = A − in_data; carry = borrow (1 when in_data > A).
  - 3 AND, 4 OR, 5 XOR: R = A op in_data.
  - 6 LOAD: R = in_data.
  - 7 CLR: R = 0.
- Carry is 0 for every opcode except ADD and SUB.
- For opcodes 1–7, A is updated to R on the accept edge.
- Each accepted beat pushes {R, carry, R==0} into the buffer.
- The buffer pops when `out_valid && out_ready`.
- `in_ready = !rst && (count < DEPTH)`; it depends on registered count only, with no combinational path from `out_ready`.
- When full, a pop frees space, but `in_ready` rises only on the following cycle.
- Simultaneous push and pop: count is unchanged and ordering is preserved.
- A pop while empty or a push while full cannot occur by construction; assertions check both.

## Timing
- Latency is 1 cycle. A beat accepted at edge N is at the head after edge N when the buffer is empty, so `out_valid` is high in cycle N+1.
- Back-to-back ADDs use the accumulator value updated on the previous edge; there is no hazard bubble.
- Reset, asynchronous on assertion:
  - `acc` = 0, count = 0.
  - `out_valid` = 0, `out_data` = 0, `out_carry` = 0, `out_zero` = 0.
  - `in_ready` = 0 while `rst` is high and 1 on the first cycle after release.
- Reset mid-operation: buffered results are discarded; in-flight beats are not completed.
- The head outputs (`out_data`/`out_carry`/`out_zero`) are held stable while `out_valid && !out_ready`.

## Configuration
- `ALU_SAT_EN` defined:
  - ADD clamps to all-ones on carry.
  - SUB clamps to 0 on borrow.
  - `out_carry` still reports the overflow or borrow.
  - The clamped value is what goes to the buffer and the accumulator.
- Not defined: ADD and SUB wrap modulo 2^WIDTH.

## Structure
- Shared package `mux_alu_pkg`: `alu_op_e` enum (3-bit), `ALU_WIDTH` = 8, `ALU_DEPTH` = 2, and a packed `alu_res_t` {data, carry, zero}.
- Sub-module `alu_out_fifo`: a parameterised `alu_res_t` buffer with push/pop/count/full/empty. The ALU datapath and accumulator stay in the top module.

## Test plan
- Reset, then LOAD 0x10, ADD 0x05 with `out_ready`=1 → results 0x10 then 0x15, carry 0, `acc`=0x15.
- LOAD 0xF0, ADD 0x20 → without `ALU_SAT_EN`: 0x10, carry 1. With `ALU_SAT_EN`: 0xFF, carry 1.
- LOAD 0x03, SUB 0x05 → without `ALU_SAT_EN`: 0xFE, carry 1. With `ALU_SAT_EN`: 0x00, carry 1, zero 1.
- Back-pressure: `out_ready`=0, offer LOAD 0x01, PASS 0x02, PASS 0x03 → two beats accepted and `in_ready`=0. Then `out_ready`=1 → outputs 0x01, 0x02, 0x03 in order, and `in_ready` returns one cycle after the first pop.
- Simultaneous push/pop with one entry held, streaming PASS beats at full rate → count stays 1, `out_valid` never drops, no beat is lost.
- Assert `rst` for 1 cycle with 2 entries buffered and `acc`=0x15 → `out_valid`=0 and `acc`=0 immediately. After release, PASS 0x07 → 0x07 is output one cycle after acceptance.

Source files
------------

// File: rtl/mux_alu_pkg.sv
// Shared types for the mux ALU stage: opcode enum, default sizes, result record.
// The ALU_SAT_EN build option is handled in mux_alu_stage.
package mux_alu_pkg;

  localparam int ALU_WIDTH = 8;
  localparam int ALU_DEPTH = 2;

  typedef enum logic [2:0] {
    OP_PASS = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_AND  = 3'd3,
    OP_OR   = 3'd4,
    OP_XOR  = 3'd5,
    OP_LOAD = 3'd6,
    OP_CLR  = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] data;
    logic                 carry;
    logic                 zero;
  } alu_res_t;

endpackage

// File: rtl/alu_out_fifo.sv
// Small result buffer with push/pop, occupancy count and full/empty flags.
// Storage is cleared on reset so the head reads as zero while empty after reset.
module alu_out_fifo
  import mux_alu_pkg::*;
#(
  parameter int  DEPTH  = ALU_DEPTH,
  parameter type item_t = alu_res_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  item_t                      wr_item,
  output item_t                      head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  item_t          mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_item;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/mux_alu_stage.sv
// Accumulator ALU stage behind the 4:1 operand mux, with a buffered valid/ready output.
// Define ALU_SAT_EN to clamp ADD/SUB results instead of wrapping.
module mux_alu_stage
  import mux_alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = ALU_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero,
  output logic [WIDTH-1:0] acc
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             carry;
    logic             zero;
  } res_t;

  alu_op_e        op;
  res_t           res;
  res_t           head;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic [CW-1:0]  count;
  logic           full;
  logic           empty;
  logic           push;
  logic           pop;

  assign op       = alu_op_e'(in_op);
  // Registered count only: consumer ready never reaches in_ready combinationally.
  assign in_ready = !rst && (count < CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  always_comb begin
    sum  = {1'b0, acc} + {1'b0, in_data};
    diff = {1'b0, acc} - {1'b0, in_data};
    res  = '0;
    case (op)
      OP_PASS: res.data = in_data;
      OP_ADD: begin
        res.carry = sum[WIDTH];
`ifdef ALU_SAT_EN
        res.data  = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
        res.data  = sum[WIDTH-1:0];
`endif
      end
      OP_SUB: begin
        res.carry = diff[WIDTH];
`ifdef ALU_SAT_EN
        res.data  = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
`else
        res.data  = diff[WIDTH-1:0];
`endif
      end
      OP_AND:  res.data = acc & in_data;
      OP_OR:   res.data = acc | in_data;
      OP_XOR:  res.data = acc ^ in_data;
      OP_LOAD: res.data = in_data;
      OP_CLR:  res.data = '0;
      default: res.data = '0;
    endcase
    res.zero = (res.data == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (push && (op != OP_PASS)) begin
      acc <= res.data;
    end
  end

  alu_out_fifo #(
    .DEPTH  (DEPTH),
    .item_t (res_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_item (res),
    .head    (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  assign out_valid = !empty;
  assign out_data  = head.data;
  assign out_carry = head.carry;
  assign out_zero  = head.zero;

  a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: tb/tb_mux_alu_stage.sv
// Directed self-checking bench for mux_alu_stage (expectations follow ALU_SAT_EN when defined).
module tb_mux_alu_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_carry;
  logic       out_zero;
  logic [7:0] acc;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] PASS = 3'd0, ADD = 3'd1, SUB = 3'd2, AND_ = 3'd3,
                         OR_ = 3'd4, XOR_ = 3'd5, LOAD = 3'd6, CLR = 3'd7;

  mux_alu_stage #(.WIDTH(8), .DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .out_zero  (out_zero),
    .acc       (acc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one beat for a single edge, then sample 1 time unit after that edge.
  task automatic beat(input logic [2:0] op, input logic [7:0] d);
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic head_chk(input string tag, input logic [7:0] d, input logic c, input logic z);
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_data"},  out_data,  d);
    chk({tag, "_carry"}, out_carry, c);
    chk({tag, "_zero"},  out_zero,  z);
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_op = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  in_ready,  1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data",  out_data,  8'h00);
    chk("rst_acc",       acc,       8'h00);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1'b1);

    // Basic LOAD then back-to-back ADD
    beat(LOAD, 8'h10);
    head_chk("load10", 8'h10, 1'b0, 1'b0);
    chk("load10_acc", acc, 8'h10);
    beat(ADD, 8'h05);
    head_chk("add05", 8'h15, 1'b0, 1'b0);
    chk("add05_acc", acc, 8'h15);
    idle();
    chk("drain1_valid", out_valid, 1'b0);

    // ADD overflow
    beat(LOAD, 8'hF0);
    head_chk("loadf0", 8'hF0, 1'b0, 1'b0);
    beat(ADD, 8'h20);
`ifdef ALU_SAT_EN
    head_chk("add_ovf", 8'hFF, 1'b1, 1'b0);
    chk("add_ovf_acc", acc, 8'hFF);
`else
    head_chk("add_ovf", 8'h10, 1'b1, 1'b0);
    chk("add_ovf_acc", acc, 8'h10);
`endif

    // SUB borrow
    beat(LOAD, 8'h03);
    beat(SUB, 8'h05);
`ifdef ALU_SAT_EN
    head_chk("sub_brw", 8'h00, 1'b1, 1'b1);
    chk("sub_brw_acc", acc, 8'h00);
`else
    head_chk("sub_brw", 8'hFE, 1'b1, 1'b0);
    chk("sub_brw_acc", acc, 8'hFE);
`endif

    // Logic ops, PASS leaves acc alone, CLR
    beat(LOAD, 8'hCC);
    beat(AND_, 8'hAA);
    head_chk("and", 8'h88, 1'b0, 1'b0);
    beat(OR_, 8'h11);
    head_chk("or", 8'h99, 1'b0, 1'b0);
    beat(XOR_, 8'hFF);
    head_chk("xor", 8'h66, 1'b0, 1'b0);
    beat(PASS, 8'h42);
    head_chk("pass", 8'h42, 1'b0, 1'b0);
    chk("pass_acc", acc, 8'h66);
    beat(CLR, 8'h55);
    head_chk("clr", 8'h00, 1'b0, 1'b1);
    chk("clr_acc", acc, 8'h00);
    idle();
    chk("drain2_valid", out_valid, 1'b0);

    // Back-pressure: buffer fills at two, third beat waits
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = LOAD; in_data = 8'h01;
    @(posedge clk); #1;
    in_op = PASS; in_data = 8'h02;
    @(posedge clk); #1;
    chk("bp_full_in_ready", in_ready, 1'b0);
    in_data = 8'h03;
    @(posedge clk); #1;
    chk("bp_stall_in_ready", in_ready, 1'b0);
    chk("bp_hold_data", out_data, 8'h01);
    chk("bp_acc", acc, 8'h01);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_pop1_in_ready", in_ready, 1'b1);
    chk("bp_pop1_data", out_data, 8'h02);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_pop2_data", out_data, 8'h03);
    chk("bp_pop2_valid", out_valid, 1'b1);
    idle();
    chk("bp_drain_valid", out_valid, 1'b0);

    // Streaming with one entry held: push and pop together every edge
    out_ready = 1'b0;
    beat(PASS, 8'h30);
    out_ready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      in_valid = 1'b1; in_op = PASS; in_data = 8'h30 + 8'(i);
      @(posedge clk); #1;
      chk("stream_valid", out_valid, 1'b1);
      chk("stream_data", out_data, 8'h30 + 8'(i));
      chk("stream_in_ready", in_ready, 1'b1);
    end
    in_valid = 1'b0;
    idle();
    chk("stream_end_valid", out_valid, 1'b0);

    // Reset with two entries buffered and acc = 0x15
    out_ready = 1'b0;
    beat(LOAD, 8'h10);
    beat(ADD, 8'h05);
    chk("pre_rst_acc", acc, 8'h15);
    chk("pre_rst_in_ready", in_ready, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_acc", acc, 8'h00);
    chk("mid_rst_data", out_data, 8'h00);
    chk("mid_rst_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("post_rst_valid", out_valid, 1'b0);
    chk("post_rst_in_ready", in_ready, 1'b1);
    beat(PASS, 8'h07);
    head_chk("post_rst_pass", 8'h07, 1'b0, 1'b0);
    chk("post_rst_acc", acc, 8'h00);
    idle();
    chk("final_valid", out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
